// File: rtl/fft_stage_sequencer.sv
// Sequences one FFT frame through a shared stage datapath, one pass per stage,
// writing each pass result back into the frame register before the next issue.
module fft_stage_sequencer #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned SIZE_FFT  = 8,
    parameter int unsigned N_STAGES  = $clog2(SIZE_FFT),
    parameter int unsigned STAGE_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [2*BIT_WIDTH*SIZE_FFT-1:0]   recv_msg,
    input  logic                              recv_val,
    output logic                              recv_rdy,
    output logic [2*BIT_WIDTH*SIZE_FFT-1:0]   send_msg,
    output logic                              send_val,
    input  logic                              send_rdy,
    output logic [2*BIT_WIDTH*SIZE_FFT-1:0]   dp_send_msg,
    output logic                              dp_send_val,
    input  logic                              dp_send_rdy,
    input  logic [2*BIT_WIDTH*SIZE_FFT-1:0]   dp_recv_msg,
    input  logic                              dp_recv_val,
    output logic                              dp_recv_rdy,
    output logic [STAGE_W-1:0]                stage,
    output logic                              busy
);

    localparam int unsigned FRAME_W = 2*BIT_WIDTH*SIZE_FFT;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES-1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic                 recv_rdy_q, send_val_q, dp_send_val_q, dp_recv_rdy_q, busy_q;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        stage_d = stage_q;
        unique case (state_q)
            IDLE: begin
                if (recv_val && recv_rdy_q) begin
                    frame_d = recv_msg;
                    stage_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (dp_send_val_q && dp_send_rdy) state_d = WAIT;
            end
            WAIT: begin
                // The last pass keeps its stage index; it is cleared on the way back to IDLE.
                if (dp_recv_val && dp_recv_rdy_q) begin
                    frame_d = dp_recv_msg;
                    if (stage_q == LAST_STAGE) begin
                        state_d = DONE;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                if (send_val_q && send_rdy) begin
                    state_d = IDLE;
                    stage_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            stage_q       <= '0;
            recv_rdy_q    <= 1'b1;
            send_val_q    <= 1'b0;
            dp_send_val_q <= 1'b0;
            dp_recv_rdy_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            stage_q       <= stage_d;
            recv_rdy_q    <= (state_d == IDLE);
            send_val_q    <= (state_d == DONE);
            dp_send_val_q <= (state_d == ISSUE);
            dp_recv_rdy_q <= (state_d == WAIT);
            busy_q        <= (state_d != IDLE);
        end
    end

    assign recv_rdy    = recv_rdy_q;
    assign send_val    = send_val_q;
    assign send_msg    = frame_q;
    assign dp_send_val = dp_send_val_q;
    assign dp_send_msg = frame_q;
    assign dp_recv_rdy = dp_recv_rdy_q;
    assign stage       = stage_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: dut0 is BIT_WIDTH=4/SIZE_FFT=4 (two passes), dut1 is BIT_WIDTH=8/SIZE_FFT=2 (one pass).
module tb_fft_stage_sequencer;

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic [1:0]       reset;
    logic [1:0][31:0] recv_msg, send_msg, dp_send_msg, dp_recv_msg;
    logic [1:0]       recv_val, recv_rdy, send_val, send_rdy;
    logic [1:0]       dp_send_val, dp_send_rdy, dp_recv_val, dp_recv_rdy;
    logic [1:0]       stage, busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t exp_q [2][$];
    int   last_send [2];
    int   dstall_n [2];
    int   sstall_n [2];
    logic [1:0] dstall_st;
    logic [1:0] spur;

    fft_stage_sequencer #(.BIT_WIDTH(4), .SIZE_FFT(4)) u_dut4 (
        .clk(clk), .reset(reset[0]),
        .recv_msg(recv_msg[0]), .recv_val(recv_val[0]), .recv_rdy(recv_rdy[0]),
        .send_msg(send_msg[0]), .send_val(send_val[0]), .send_rdy(send_rdy[0]),
        .dp_send_msg(dp_send_msg[0]), .dp_send_val(dp_send_val[0]), .dp_send_rdy(dp_send_rdy[0]),
        .dp_recv_msg(dp_recv_msg[0]), .dp_recv_val(dp_recv_val[0]), .dp_recv_rdy(dp_recv_rdy[0]),
        .stage(stage[0]), .busy(busy[0])
    );

    fft_stage_sequencer #(.BIT_WIDTH(8), .SIZE_FFT(2)) u_dut2 (
        .clk(clk), .reset(reset[1]),
        .recv_msg(recv_msg[1]), .recv_val(recv_val[1]), .recv_rdy(recv_rdy[1]),
        .send_msg(send_msg[1]), .send_val(send_val[1]), .send_rdy(send_rdy[1]),
        .dp_send_msg(dp_send_msg[1]), .dp_send_val(dp_send_val[1]), .dp_send_rdy(dp_send_rdy[1]),
        .dp_recv_msg(dp_recv_msg[1]), .dp_recv_val(dp_recv_val[1]), .dp_recv_rdy(dp_recv_rdy[1]),
        .stage(stage[1]), .busy(busy[1])
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int n_passes(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Behavioural datapath (returns frame+1 one cycle after issue) and back-pressure knobs.
    initial begin : env
        logic [1:0]       xs, xr, pend;
        logic [1:0][31:0] xm, res;
        int cd [2];
        int cs [2];
        dp_recv_val = '0; dp_recv_msg = '0; dp_send_rdy = '1; send_rdy = '1;
        pend = '0; res = '0; cd = '{0, 0}; cs = '{0, 0};
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                xs[g] = dp_send_val[g] && dp_send_rdy[g];
                xm[g] = dp_send_msg[g];
                xr[g] = dp_recv_val[g] && dp_recv_rdy[g];
                if (recv_val[g] && recv_rdy[g]) begin
                    cd[g] = dstall_n[g];
                    cs[g] = sstall_n[g];
                end
            end
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                if (xr[g]) pend[g] = 1'b0;
                if (xs[g]) begin
                    pend[g] = 1'b1;
                    res[g]  = xm[g] + 32'd1;
                end
                if (pend[g]) begin
                    dp_recv_val[g] = 1'b1; dp_recv_msg[g] = res[g];
                end else if (spur[g]) begin
                    dp_recv_val[g] = 1'b1; dp_recv_msg[g] = 32'hFFFF_FFFF;
                end else begin
                    dp_recv_val[g] = 1'b0; dp_recv_msg[g] = '0;
                end
                if (dp_send_val[g] && stage[g] == dstall_st[g] && cd[g] > 0) begin
                    dp_send_rdy[g] = 1'b0; cd[g]--;
                end else begin
                    dp_send_rdy[g] = 1'b1;
                end
                if (send_val[g] && cs[g] > 0) begin
                    send_rdy[g] = 1'b0; cs[g]--;
                end else begin
                    send_rdy[g] = 1'b1;
                end
            end
        end
    end

    // Monitor: pass-by-pass issue checks, hold checks under back-pressure, scoreboard on send.
    initial begin : mon
        logic [1:0][31:0] cur_in, ds_msg, s_msg;
        logic [1:0]       ds_hold, s_hold, ds_stage;
        int pass [2];
        exp_t e;
        cur_in = '0; ds_msg = '0; s_msg = '0; ds_hold = '0; s_hold = '0; ds_stage = '0;
        pass = '{0, 0};
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("dut%0d busy_vs_recv_rdy", g), 32'(busy[g]), 32'(!recv_rdy[g]));
                if (recv_val[g] && recv_rdy[g]) begin
                    cur_in[g] = recv_msg[g];
                    pass[g]   = 0;
                end
                if (ds_hold[g]) begin
                    chk($sformatf("dut%0d dp_send_val_held", g), 32'(dp_send_val[g]), 32'd1);
                    chk($sformatf("dut%0d dp_send_msg_held", g), dp_send_msg[g], ds_msg[g]);
                    chk($sformatf("dut%0d stage_held", g), 32'(stage[g]), 32'(ds_stage[g]));
                end
                if (s_hold[g]) begin
                    chk($sformatf("dut%0d send_val_held", g), 32'(send_val[g]), 32'd1);
                    chk($sformatf("dut%0d send_msg_held", g), send_msg[g], s_msg[g]);
                end
                if (dp_send_val[g] && dp_send_rdy[g]) begin
                    chk($sformatf("dut%0d issue_stage", g), 32'(stage[g]), 32'(pass[g]));
                    chk($sformatf("dut%0d issue_msg", g), dp_send_msg[g], cur_in[g] + 32'(pass[g]));
                    if (pass[g] >= n_passes(g)) begin
                        checks++; errors++;
                        $display("FAIL dut%0d issue_count: got %0d issues expected %0d", g, pass[g] + 1, n_passes(g));
                    end
                    pass[g]++;
                end
                if (dp_recv_val[g] && dp_recv_rdy[g])
                    chk($sformatf("dut%0d wait_stage", g), 32'(stage[g]), 32'(pass[g] - 1));
                ds_hold[g]  = dp_send_val[g] && !dp_send_rdy[g];
                ds_msg[g]   = dp_send_msg[g];
                ds_stage[g] = stage[g];
                s_hold[g]   = send_val[g] && !send_rdy[g];
                s_msg[g]    = send_msg[g];
                if (send_val[g] && send_rdy[g]) begin
                    if (exp_q[g].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dut%0d unexpected_send: got %h expected no send", g, send_msg[g]);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("dut%0d send_msg", g), send_msg[g], e.data);
                        chk($sformatf("dut%0d latency", g), 32'(cyc + 1 - e.acc), 32'(e.lat));
                    end
                    last_send[g] = cyc + 1;
                end
            end
        end
    end

    task automatic put(input int g, input logic [31:0] d, input int extra, output int acc);
        int n;
        exp_t e;
        recv_msg[g] = d;
        recv_val[g] = 1'b1;
        acc = -1;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (recv_rdy[g]) break;
            n++;
        end
        if (!recv_rdy[g]) begin
            timeout_fail($sformatf("dut%0d recv_accept", g));
            recv_val[g] = 1'b0;
            return;
        end
        acc    = cyc + 1;
        e.data = d + 32'(n_passes(g));
        e.acc  = acc;
        e.lat  = 2*n_passes(g) + 1 + extra;
        exp_q[g].push_back(e);
        @(posedge clk);
        #1;
        recv_val[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (exp_q[g].size() == 0 && recv_rdy[g]) break;
            n++;
        end
        if (!(exp_q[g].size() == 0 && recv_rdy[g])) timeout_fail($sformatf("dut%0d frame_complete", g));
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int g, input logic [31:0] d, input logic dst, input int dsn, input int ssn);
        int acc;
        dstall_st[g] = dst;
        dstall_n[g]  = dsn;
        sstall_n[g]  = ssn;
        put(g, d, dsn + ssn, acc);
        wait_idle(g);
    endtask

    task automatic check_idle(input int g, input string tag);
        chk($sformatf("dut%0d %s recv_rdy", g, tag), 32'(recv_rdy[g]), 32'd1);
        chk($sformatf("dut%0d %s busy", g, tag), 32'(busy[g]), 32'd0);
        chk($sformatf("dut%0d %s stage", g, tag), 32'(stage[g]), 32'd0);
        chk($sformatf("dut%0d %s send_val", g, tag), 32'(send_val[g]), 32'd0);
        chk($sformatf("dut%0d %s dp_send_val", g, tag), 32'(dp_send_val[g]), 32'd0);
        chk($sformatf("dut%0d %s dp_recv_rdy", g, tag), 32'(dp_recv_rdy[g]), 32'd0);
        chk($sformatf("dut%0d %s frame", g, tag), dp_send_msg[g], 32'd0);
    endtask

    initial begin : stim
        int acc, n;
        reset = '1; recv_val = '0; recv_msg = '0;
        dstall_n = '{0, 0}; sstall_n = '{0, 0}; dstall_st = '0; spur = '0;
        last_send = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        check_idle(0, "reset");
        check_idle(1, "reset");
        reset = '0;
        @(posedge clk);
        #1;

        // dut0 directed cases
        run(0, 32'h10, 1'b0, 0, 0);
        run(0, 32'h10, 1'b1, 3, 0);
        dstall_st[0] = 1'b0; dstall_n[0] = 0; sstall_n[0] = 4;
        put(0, 32'h10, 4, acc);
        sstall_n[0] = 0;
        put(0, 32'h30, 0, acc);
        chk("dut0 accept_after_send", 32'(acc), 32'(last_send[0] + 1));
        wait_idle(0);
        spur[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run(0, 32'h10, 1'b0, 0, 0);
        spur[0] = 1'b0;

        // Abort in the second WAIT: the queued expectation is dropped since no send may follow.
        put(0, 32'h10, 0, acc);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (dp_recv_rdy[0] && stage[0] == 1'b1) break;
            n++;
        end
        if (!(dp_recv_rdy[0] && stage[0] == 1'b1)) timeout_fail("dut0 reach_wait_stage1");
        #1;
        reset[0] = 1'b1;
        if (exp_q[0].size() > 0) void'(exp_q[0].pop_back());
        @(posedge clk);
        #1;
        reset[0] = 1'b0;
        check_idle(0, "abort");
        run(0, 32'h20, 1'b0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            spur[0] = 1'($urandom_range(0, 1));
            run(0, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        spur[0] = 1'b0;

        // dut1: single pass per frame
        run(1, 32'h05, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            spur[1] = 1'($urandom_range(0, 1));
            run(1, $urandom, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        spur[1] = 1'b0;

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
